// File: rtl/emif_reg_slave.sv
// rtl/emif_reg_slave.sv - EMIF register slave: strobe sync, register map, line_done interrupt
// Optional read path enabled by macro EMIF_REG_READBACK_EN.
module emif_reg_slave #(
    parameter logic [31:0] ID_VALUE  = 32'h534E_5201,
    parameter int          INT_WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        emif_ce,
    input  logic        emif_we,
    input  logic        emif_re,
    input  logic [3:0]  emif_addr,
    input  logic [31:0] emif_din,
    output logic [31:0] emif_dout,
    output logic        emif_oe,
    input  logic        line_done,
    output logic        dsp_int,
    output logic        start_init,
    output logic        start_cis,
    output logic [15:0] sp_para,
    output logic [8:0]  cmd_config1,
    output logic [8:0]  cmd_mux1,
    output logic [8:0]  cmd_gaina1,
    output logic [8:0]  cmd_gainb1,
    output logic [8:0]  cmd_offseta1,
    output logic [8:0]  cmd_offsetb1,
    output logic [8:0]  cmd_config2,
    output logic [8:0]  cmd_mux2,
    output logic [8:0]  cmd_gaina2,
    output logic [8:0]  cmd_gainb2,
    output logic [8:0]  cmd_offseta2,
    output logic [8:0]  cmd_offsetb2
);

    localparam logic [7:0] INT_M1 = 8'(INT_WIDTH - 1);

    // Bit 0 = s1, bit 1 = s2, bit 2 = s3 (edge reference).
    logic [2:0] ce_q, we_q, re_q, ld_q;

    logic       wr_commit, ld_rise, wr_ad;
    logic [3:0] ad_idx;
    logic [8:0] ad_q [12];
    logic [7:0] line_cnt, int_cnt;
    logic       line_flag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ce_q <= '0;
            we_q <= '0;
            re_q <= '0;
            ld_q <= '0;
        end else begin
            ce_q <= {ce_q[1:0], emif_ce};
            we_q <= {we_q[1:0], emif_we};
            re_q <= {re_q[1:0], emif_re};
            ld_q <= {ld_q[1:0], line_done};
        end
    end

    assign wr_commit = !we_q[1] && we_q[2] && !ce_q[1];
    assign ld_rise   = ld_q[1] && !ld_q[2];
    assign ad_idx    = emif_addr - 4'd2;
    assign wr_ad     = wr_commit && (emif_addr >= 4'd2) && (emif_addr <= 4'd13);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_init <= 1'b0;
            start_cis  <= 1'b0;
            sp_para    <= '0;
            for (int i = 0; i < 12; i++) ad_q[i] <= '0;
            line_flag  <= 1'b0;
            line_cnt   <= '0;
            int_cnt    <= '0;
            dsp_int    <= 1'b0;
        end else begin
            start_init <= wr_commit && (emif_addr == 4'd0) && emif_din[0];
            start_cis  <= wr_commit && (emif_addr == 4'd0) && emif_din[1];
            if (wr_commit && (emif_addr == 4'd1)) sp_para <= emif_din[15:0];
            if (wr_ad) ad_q[ad_idx] <= emif_din[8:0];

            // A new line always wins over a same-cycle clear of the flag.
            if (ld_rise) begin
                line_flag <= 1'b1;
                line_cnt  <= line_cnt + 8'd1;
            end else if (wr_commit && (emif_addr == 4'd14) && emif_din[0]) begin
                line_flag <= 1'b0;
            end

            if (ld_rise) begin
                dsp_int <= 1'b1;
                int_cnt <= INT_M1;
            end else if (int_cnt != 8'd0) begin
                int_cnt <= int_cnt - 8'd1;
            end else begin
                dsp_int <= 1'b0;
            end
        end
    end

    assign cmd_config1  = ad_q[0];
    assign cmd_mux1     = ad_q[1];
    assign cmd_gaina1   = ad_q[2];
    assign cmd_gainb1   = ad_q[3];
    assign cmd_offseta1 = ad_q[4];
    assign cmd_offsetb1 = ad_q[5];
    assign cmd_config2  = ad_q[6];
    assign cmd_mux2     = ad_q[7];
    assign cmd_gaina2   = ad_q[8];
    assign cmd_gainb2   = ad_q[9];
    assign cmd_offseta2 = ad_q[10];
    assign cmd_offsetb2 = ad_q[11];

`ifdef EMIF_REG_READBACK_EN
    logic        rd_latch;
    logic [31:0] rd_data;

    assign rd_latch = !re_q[1] && re_q[2] && !ce_q[1];

    always_comb begin
        rd_data = '0;
        case (emif_addr)
            4'd0:  rd_data = '0;
            4'd1:  rd_data = {16'h0, sp_para};
            4'd14: rd_data = {16'h0, line_cnt, 7'h0, line_flag};
            4'd15: rd_data = ID_VALUE;
            default: rd_data = {23'h0, ad_q[ad_idx]};
        endcase
    end

    // Output enable holds until either strobe is seen released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            emif_dout <= '0;
            emif_oe   <= 1'b0;
        end else if (rd_latch) begin
            emif_dout <= rd_data;
            emif_oe   <= 1'b1;
        end else if (re_q[1] || ce_q[1]) begin
            emif_oe   <= 1'b0;
        end
    end

    logic unused_rd;
    assign unused_rd = ^{emif_din[31:16], ce_q[2]};
`else
    assign emif_dout = '0;
    assign emif_oe   = 1'b0;

    logic unused_rd;
    assign unused_rd = ^{emif_din[31:16], ce_q[2], re_q, line_cnt, line_flag};
`endif

endmodule

// File: tb/tb_emif_reg_slave.sv
// tb/tb_emif_reg_slave.sv - directed bench for emif_reg_slave (both EMIF_REG_READBACK_EN builds)
module tb_emif_reg_slave;

`ifdef EMIF_REG_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        emif_ce, emif_we, emif_re;
    logic [3:0]  emif_addr;
    logic [31:0] emif_din;
    logic [31:0] emif_dout;
    logic        emif_oe;
    logic        line_done;
    logic        dsp_int, start_init, start_cis;
    logic [15:0] sp_para;
    logic [8:0]  cmd_config1, cmd_mux1, cmd_gaina1, cmd_gainb1, cmd_offseta1, cmd_offsetb1;
    logic [8:0]  cmd_config2, cmd_mux2, cmd_gaina2, cmd_gainb2, cmd_offseta2, cmd_offsetb2;

    int n_chk  = 0;
    int n_pass = 0;

    emif_reg_slave #(.ID_VALUE(32'h534E_5201), .INT_WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .emif_ce(emif_ce), .emif_we(emif_we), .emif_re(emif_re),
        .emif_addr(emif_addr), .emif_din(emif_din),
        .emif_dout(emif_dout), .emif_oe(emif_oe),
        .line_done(line_done), .dsp_int(dsp_int),
        .start_init(start_init), .start_cis(start_cis), .sp_para(sp_para),
        .cmd_config1(cmd_config1), .cmd_mux1(cmd_mux1), .cmd_gaina1(cmd_gaina1),
        .cmd_gainb1(cmd_gainb1), .cmd_offseta1(cmd_offseta1), .cmd_offsetb1(cmd_offsetb1),
        .cmd_config2(cmd_config2), .cmd_mux2(cmd_mux2), .cmd_gaina2(cmd_gaina2),
        .cmd_gainb2(cmd_gainb2), .cmd_offseta2(cmd_offseta2), .cmd_offsetb2(cmd_offsetb2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic start_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        emif_addr = a;
        emif_din  = d;
        emif_ce   = 1'b0;
        emif_we   = 1'b0;
    endtask

    task automatic release_strobe();
        emif_ce = 1'b1;
        emif_we = 1'b1;
        emif_re = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d);
        start_write(a, d);
        repeat (6) @(negedge clk);
        release_strobe();
    endtask

    // Read with oe sampled mid-strobe, two cycles after release and three after release.
    task automatic do_read(input logic [3:0] a, output logic [31:0] d,
                           output logic oe_mid, output logic oe_hold, output logic oe_off);
        @(negedge clk);
        emif_addr = a;
        emif_ce   = 1'b0;
        emif_re   = 1'b0;
        repeat (5) @(negedge clk);
        d      = emif_dout;
        oe_mid = emif_oe;
        emif_ce = 1'b1;
        emif_re = 1'b1;
        @(negedge clk);
        @(negedge clk);
        oe_hold = emif_oe;
        @(negedge clk);
        oe_off = emif_oe;
        repeat (3) @(negedge clk);
    endtask

    task automatic read_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic        m, h, o;
        do_read(a, d, m, h, o);
        check({tag, "_data"}, d, RB ? exp : 32'h0);
        check({tag, "_oe"}, {31'h0, m}, {31'h0, RB});
    endtask

    initial begin
        logic [31:0] d;
        logic        m, h, o, prev, init_p3;
        int          n_i, n_c, hi, rises;

        reset = 1'b1;
        emif_ce = 1'b1; emif_we = 1'b1; emif_re = 1'b1;
        emif_addr = '0; emif_din = '0; line_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dsp_int", {31'h0, dsp_int}, 32'h0);
        check("rst_pulses", {30'h0, start_init, start_cis}, 32'h0);
        check("rst_sp_para", {16'h0, sp_para}, 32'h0);
        check("rst_oe_dout", emif_dout | {31'h0, emif_oe}, 32'h0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Write gaina1: not visible after 2 edges, visible after the third.
        start_write(4'd4, 32'h0000_01A5);
        @(negedge clk);
        @(negedge clk);
        check("gaina1_early", {23'h0, cmd_gaina1}, 32'h0);
        @(negedge clk);
        check("gaina1_commit", {23'h0, cmd_gaina1}, 32'h1A5);
        check("gaina2_untouched", {23'h0, cmd_gaina2}, 32'h0);
        repeat (4) @(negedge clk);
        release_strobe();

        // CTRL pulses, one per strobe even with a long hold.
        start_write(4'd0, 32'h3);
        n_i = 0; n_c = 0; init_p3 = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 3) init_p3 = start_init;
            n_i += int'(start_init);
            n_c += int'(start_cis);
        end
        release_strobe();
        check("start_init_cycles", n_i, 1);
        check("start_cis_cycles", n_c, 1);
        check("start_init_timing", {31'h0, init_p3}, 32'h1);
        start_write(4'd0, 32'h2);
        n_i = 0; n_c = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            n_i += int'(start_init);
            n_c += int'(start_cis);
        end
        release_strobe();
        check("cis_only_init", n_i, 0);
        check("cis_only_cis", n_c, 1);
        read_check("rd_ctrl", 4'd0, 32'h0);
        read_check("rd_gaina1", 4'd4, 32'h1A5);

        // Other map entries, upper-bit masking and ID write-protection.
        do_write(4'd1, 32'hDEAD_BEEF);
        check("sp_para", {16'h0, sp_para}, 32'hBEEF);
        do_write(4'd8, 32'hFFFF_FFFF);
        check("config2", {23'h0, cmd_config2}, 32'h1FF);
        check("config1_untouched", {23'h0, cmd_config1}, 32'h0);
        do_write(4'd13, 32'h0000_0A5A);
        check("offsetb2", {23'h0, cmd_offsetb2}, 32'h05A);
        do_write(4'd15, 32'h1234_5678);
        read_check("rd_sp_para", 4'd1, 32'h0000_BEEF);
        read_check("rd_offsetb2", 4'd13, 32'h0000_005A);
        do_read(4'd15, d, m, h, o);
        check("rd_id_data", d, RB ? 32'h534E_5201 : 32'h0);
        check("rd_id_oe_mid", {31'h0, m}, {31'h0, RB});
        check("rd_id_oe_hold", {31'h0, h}, {31'h0, RB});
        check("rd_id_oe_off", {31'h0, o}, 32'h0);

        // Two line_done rises 3 cycles apart stretch dsp_int to 11 cycles.
        @(negedge clk);
        line_done = 1'b1;
        hi = 0; rises = 0; prev = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 2) line_done = 1'b0;
            if (i == 3) line_done = 1'b1;
            hi += int'(dsp_int);
            if (dsp_int && !prev) rises++;
            prev = dsp_int;
        end
        check("dsp_int_len_ext", hi, 11);
        check("dsp_int_contiguous", rises, 1);
        read_check("rd_status_2", 4'd14, 32'h0000_0201);

        // Clear of the flag in the same cycle as a new line: set wins.
        line_done = 1'b0;
        repeat (5) @(negedge clk);
        emif_addr = 4'd14; emif_din = 32'h1;
        emif_ce = 1'b0; emif_we = 1'b0; line_done = 1'b1;
        hi = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            hi += int'(dsp_int);
        end
        release_strobe();
        check("dsp_int_len_single", hi, 8);
        read_check("rd_status_setwins", 4'd14, 32'h0000_0301);
        do_write(4'd14, 32'h1);
        read_check("rd_status_cleared", 4'd14, 32'h0000_0300);

        // Reset mid-pulse aborts dsp_int and clears registers asynchronously.
        line_done = 1'b0;
        repeat (5) @(negedge clk);
        line_done = 1'b1;
        repeat (5) @(negedge clk);
        check("dsp_int_before_rst", {31'h0, dsp_int}, 32'h1);
        reset = 1'b1;
        #1;
        check("dsp_int_abort", {31'h0, dsp_int}, 32'h0);
        check("gaina1_cleared", {23'h0, cmd_gaina1}, 32'h0);
        line_done = 1'b0;

        // we held low across reset release must not commit.
        emif_addr = 4'd5; emif_din = 32'h1FF;
        emif_ce = 1'b0; emif_we = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("no_commit_at_release", {23'h0, cmd_gainb1}, 32'h0);
        check("no_dsp_int_after_rst", {31'h0, dsp_int}, 32'h0);
        release_strobe();
        do_write(4'd5, 32'h0AB);
        check("commit_after_release", {23'h0, cmd_gainb1}, 32'h0AB);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
